// File: rtl/alu_reg_unit.sv
// PicoComputer datapath slice: a combinational ALU (zero latency) beside a general-purpose register (one-cycle update).
// Neither half stalls or backpressures. The register clears asynchronously while rst_n is high.
module alu_reg_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    input  logic             cl,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             sl,
    input  logic             ir,
    input  logic             il,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    always_comb begin
        f = '0;
        case (oc)
            3'b000:  f = a + b;
            3'b001:  f = a - b;
            3'b010:  f = a * b;
            // Division by zero yields 0 rather than X.
            3'b011:  f = (b == '0) ? '0 : a / b;
            3'b100:  f = ~a;
            3'b101:  f = a ^ b;
            3'b110:  f = a | b;
            3'b111:  f = a & b;
            default: f = '0;
        endcase
    end

    // Controls follow a fixed priority, so only the highest active one takes effect.
    always_comb begin
        out_d = out_q;
        if (cl)
            out_d = '0;
        else if (ld)
            out_d = in;
        else if (inc)
            out_d = out_q + WIDTH'(1);
        else if (dec)
            out_d = out_q - WIDTH'(1);
        else if (sr)
            out_d = {ir, out_q[WIDTH-1:1]};
        else if (sl)
            out_d = {out_q[WIDTH-2:0], il};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_alu_reg_unit.sv
// Bench for alu_reg_unit: stimulus queues expected values; a monitor checks them on the falling edge.
module tb_alu_reg_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] oc;
    logic [3:0] a, b, f;
    logic       cl, ld, inc, dec, sr, sl, ir, il;
    logic [3:0] din, dout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      lbl;
        logic [3:0] exp_f;
        logic [3:0] exp_out;
    } exp_t;

    exp_t sb_q[$];
    int   model_out = 0;

    always #5 clk = ~clk;

    alu_reg_unit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .oc(oc), .a(a), .b(b), .f(f),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
        .ir(ir), .il(il), .in(din), .out(dout)
    );

    function automatic int alu_ref(input int op, input int x, input int y);
        case (op)
            0: return (x + y) % 16;
            1: return (x - y + 16) % 16;
            2: return (x * y) % 16;
            3: return (y == 0) ? 0 : x / y;
            4: return 15 - x;
            5: return x ^ y;
            6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // c = {cl, ld, inc, dec, sr, sl}
    function automatic int reg_ref(input int cur, input logic [5:0] c, input int ir_v, input int il_v, input int in_v);
        if (c[5]) return 0;
        if (c[4]) return in_v;
        if (c[3]) return (cur + 1) % 16;
        if (c[2]) return (cur + 15) % 16;
        if (c[1]) return (cur / 2) + 8 * ir_v;
        if (c[0]) return ((cur * 2) % 16) + il_v;
        return cur;
    endfunction

    // Called just after a rising edge. rmode: 0 none, 1 reset pulse released mid-cycle, 2 reset held across the next edge.
    task automatic cyc(input string lbl, input logic [5:0] c, input logic ir_v, input logic il_v,
                       input logic [3:0] in_v, input logic [2:0] oc_v, input logic [3:0] a_v,
                       input logic [3:0] b_v, input int rmode);
        exp_t e;
        {cl, ld, inc, dec, sr, sl} = c;
        ir = ir_v; il = il_v; din = in_v; oc = oc_v; a = a_v; b = b_v;
        rst_n = (rmode != 0);
        if (rmode != 0) model_out = 0;
        e.lbl = lbl;
        e.exp_f = 4'(alu_ref(int'(oc_v), int'(a_v), int'(b_v)));
        e.exp_out = 4'(model_out);
        sb_q.push_back(e);
        if (rmode != 2)
            model_out = reg_ref(model_out, c, int'(ir_v), int'(il_v), int'(in_v));
        @(negedge clk);
        #2;
        if (rmode == 1) rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (f !== e.exp_f) begin
                    bad++;
                    $display("FAIL %s f: got %0d want %0d", e.lbl, f, e.exp_f);
                end
                total++;
                if (dout !== e.exp_out) begin
                    bad++;
                    $display("FAIL %s out: got %0d want %0d", e.lbl, dout, e.exp_out);
                end
            end
        end
    end

    initial begin : stim
        logic [5:0] c;
        int rm;
        rst_n = 1'b1;
        {cl, ld, inc, dec, sr, sl, ir, il} = '0;
        din = '0; oc = '0; a = '0; b = '0;
        @(posedge clk);
        #1;
        cyc("reset_hold_ld", 6'b010000, 0, 0, 4'b1011, 3'd0, 4'd9, 4'd8, 2);

        // ALU spot checks (register holds at 0)
        cyc("add_9_8",   6'b0, 0, 0, 4'd0, 3'd0, 4'd9,  4'd8, 0);
        cyc("sub_2_5",   6'b0, 0, 0, 4'd0, 3'd1, 4'd2,  4'd5, 0);
        cyc("mul_7_3",   6'b0, 0, 0, 4'd0, 3'd2, 4'd7,  4'd3, 0);
        cyc("div_13_4",  6'b0, 0, 0, 4'd0, 3'd3, 4'd13, 4'd4, 0);
        cyc("div_by_0",  6'b0, 0, 0, 4'd0, 3'd3, 4'd11, 4'd0, 0);
        cyc("not_6",     6'b0, 0, 0, 4'd0, 3'd4, 4'd6,  4'd3, 0);
        cyc("xor",       6'b0, 0, 0, 4'd0, 3'd5, 4'b1010, 4'b0110, 0);

        // Register reset / load / hold
        cyc("ld_1011",   6'b010000, 0, 0, 4'b1011, 3'd0, 4'd0, 4'd0, 0);
        cyc("hold1",     6'b000000, 0, 0, 4'b0000, 3'd0, 4'd0, 4'd0, 0);
        cyc("hold2",     6'b000000, 0, 0, 4'b0110, 3'd0, 4'd0, 4'd0, 0);
        cyc("async_rst", 6'b010000, 0, 0, 4'b0111, 3'd0, 4'd0, 4'd0, 1);
        // Count wrap
        cyc("ld_1111",   6'b010000, 0, 0, 4'b1111, 3'd0, 4'd0, 4'd0, 0);
        cyc("inc_wrap",  6'b001000, 0, 0, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        cyc("dec_wrap",  6'b000100, 0, 0, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        cyc("inc_dec",   6'b001100, 0, 0, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        // Shifts
        cyc("ld_1001",   6'b010000, 0, 0, 4'b1001, 3'd0, 4'd0, 4'd0, 0);
        cyc("sr_ir1",    6'b000010, 1, 0, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        cyc("sl_il0",    6'b000001, 0, 0, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        cyc("sl_il1",    6'b000001, 0, 1, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        // Priority
        cyc("pri_cl",    6'b111000, 0, 0, 4'b0101, 3'd0, 4'd0, 4'd0, 0);
        cyc("pri_ld",    6'b011010, 1, 1, 4'b0101, 3'd0, 4'd0, 4'd0, 0);
        cyc("ld_0100",   6'b010000, 0, 0, 4'b0100, 3'd0, 4'd0, 4'd0, 0);
        cyc("pri_dec",   6'b000101, 0, 1, 4'd0, 3'd0, 4'd0, 4'd0, 0);
        cyc("after_pri", 6'b000000, 0, 0, 4'd0, 3'd0, 4'd0, 4'd0, 0);

        // Exhaustive ALU sweep
        for (int op = 0; op < 8; op++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    cyc("sweep", 6'b0, 0, 0, 4'd0, 3'(op), 4'(x), 4'(y), 0);

        // Randomized register + ALU traffic with occasional resets
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 6; k++) c[k] = ($urandom_range(0, 3) == 0);
            rm = $urandom_range(0, 29);
            rm = (rm == 0) ? 1 : (rm == 1) ? 2 : 0;
            cyc("random", c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rm);
        end

        repeat (4) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_reg_unit.md
Name: alu_reg_unit

Overview:
- Datapath slice of the PicoComputer CPU.
- Contains a purely combinational 4-bit ALU (8 operations selected by a 3-bit opcode).
- Contains an independent 4-bit general-purpose register with clear, load, increment, decrement and serial-fill shift controls.
- The two sub-blocks share only the clock/reset domain; the ALU ignores clock and reset.

Parameters:
WIDTH, 4, data width of ALU operands, ALU result and register.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset; asynchronous, active-high (asserting 1 clears the register)
oc  input  3  ALU opcode
a  input  WIDTH  ALU operand A
b  input  WIDTH  ALU operand B
f  output  WIDTH  ALU result (combinational)
cl  input  1  register synchronous clear
ld  input  1  register parallel load from in
inc  input  1  register increment
dec  input  1  register decrement
sr  input  1  register shift right
sl  input  1  register shift left
ir  input  1  serial bit entering MSB on shift right
il  input  1  serial bit entering LSB on shift left
in  input  WIDTH  register parallel load data
out  output  WIDTH  register contents

Behaviour:
Interface: one clock; reset is asynchronous and active-high.

ALU (combinational, zero latency, independent of clk/rst_n):
- All results are truncated to WIDTH bits; no carry/flag outputs.
- oc=000: f = a + b (modulo 2^WIDTH).
- oc=001: f = a - b (modulo 2^WIDTH, two's complement wrap).
- oc=010: f = low WIDTH bits of a * b.
- oc=011: f = a / b, unsigned, truncated; when b = 0, f = 0.
- oc=100: f = ~a (b ignored).
- oc=101: f = a ^ b.
- oc=110: f = a | b.
- oc=111: f = a & b.
- f updates whenever oc, a or b changes; there are no X outputs for any defined input.

Register (updates on rising clk edge):
- rst_n = 1 forces out = 0 immediately, regardless of clk; it holds 0 while asserted.
- Deassertion is synchronous-safe: the first update occurs at the next rising edge.
- Fixed priority when several controls are high; only the highest active operation executes:
  1. cl: out <= 0.
  2. ld: out <= in.
  3. inc: out <= out + 1, wrapping 1111 -> 0000.
  4. dec: out <= out - 1, wrapping 0000 -> 1111.
  5. sr: out <= {ir, out[WIDTH-1:1]}.
  6. sl: out <= {out[WIDTH-2:0], il}.
  7. No control active: out holds.
- ir/il are sampled only when the corresponding shift executes.
- inc and dec both high: inc wins (priority); there is no cancellation.
- Reset asserted mid-sequence: out clears immediately; pending controls are ignored until reset is released.
- Reset value of all outputs: out = 0. f is combinational, so there is no reset value.

Test Plan:
- ALU sweep: all 8 opcodes x all 256 (a,b) pairs versus a model. Spot checks:
  - oc=000, a=9, b=8 -> f=1
  - oc=001, a=2, b=5 -> f=13
  - oc=010, a=7, b=3 -> f=5
  - oc=011, a=13, b=4 -> f=3
  - oc=011, b=0 -> f=0
  - oc=100, a=6 -> f=9
  - oc=101, 1010^0110 -> f=1100
- Register reset/load: assert rst_n=1 -> out=0 without a clock edge; release, ld=1, in=1011 -> out=1011 after next edge; all controls low -> holds.
- Count wrap: load 1111, inc one edge -> 0000; dec one edge -> 1111; inc=dec=1 -> increments.
- Shifts: load 1001, sr with ir=1 -> 1100; sl with il=0 -> 1000; sl with il=1 -> 0001.
- Priority: cl=ld=inc=1, in=0101 -> out=0; ld=inc=sr=1, in=0101 -> out=0101; dec=sl=1 from 0100 -> 0011.
- Randomized: 1000 cycles of random controls/in with occasional async reset pulses mid-cycle, compared against a reference model; out must clear at the reset assertion instant.
